// File: rtl/mux_fn_sweep_ctrl.sv
// Self-check sequencer for the 4-input mux function unit: sweeps all 16 input
// vectors, captures Y into a truth table and scores it against an expected table.
module mux_fn_sweep_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expect_tt,
    output logic [3:0]  abcd,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      exp_q;
    logic             miss;
    logic [4:0]       mismatch_nxt;

    assign miss         = y ^ exp_q[idx];
    assign mismatch_nxt = mismatch_cnt + {4'd0, miss};

    // Expected table is a datapath copy; it is only read while a sweep is active.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !abort)
            exp_q <= expect_tt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            abcd         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tt           <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        tt           <= '0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        fail_valid   <= 1'b0;
                        pass         <= 1'b0;
                        idx          <= '0;
                        abcd         <= '0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Abort takes priority over a sample due on the same edge.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        abcd  <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        tt[idx]      <= y;
                        mismatch_cnt <= mismatch_nxt;
                        if (miss && !fail_valid) begin
                            first_fail <= idx;
                            fail_valid <= 1'b1;
                        end
                        if (idx == 4'd15) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (mismatch_nxt == 5'd0);
                        end else begin
                            idx  <= idx + 4'd1;
                            abcd <= idx + 4'd1;
                            cnt  <= '0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    abcd  <= '0;
                    state <= IDLE;
                    if (abort)
                        pass <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_fn_sweep_ctrl.sv
// Directed bench for mux_fn_sweep_ctrl: a table of full sweeps on a S=2 and a
// S=1 instance, plus hand-written restart, abort and async-reset sequences.
module tb_mux_fn_sweep_ctrl;

    logic        clk;
    logic        rst_n;

    logic        start0, abort0, y0, busy0, done0, pass0, fv0;
    logic [15:0] expect0, tt0, unit0;
    logic [3:0]  abcd0, ff0;
    logic [4:0]  mc0;

    logic        start1, abort1, y1, busy1, done1, pass1, fv1;
    logic [15:0] expect1, tt1, unit1;
    logic [3:0]  abcd1, ff1;
    logic [4:0]  mc1;

    int n_tests;
    int n_fail;

    // Behavioural function unit: Y is the truth-table bit selected by {A,B,C,D}.
    assign y0 = unit0[abcd0];
    assign y1 = unit1[abcd1];

    mux_fn_sweep_ctrl #(.SETTLE_CYC(2), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .expect_tt(expect0), .abcd(abcd0), .y(y0), .busy(busy0), .done(done0),
        .tt(tt0), .pass(pass0), .mismatch_cnt(mc0), .first_fail(ff0),
        .fail_valid(fv0)
    );

    mux_fn_sweep_ctrl #(.SETTLE_CYC(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .expect_tt(expect1), .abcd(abcd1), .y(y1), .busy(busy1), .done(done1),
        .tt(tt1), .pass(pass1), .mismatch_cnt(mc1), .first_fail(ff1),
        .fail_valid(fv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          which;
        logic [15:0] ufn;
        logic [15:0] exp_in;
        int          dcyc;
        logic [15:0] tt;
        logic [4:0]  mc;
        logic [3:0]  ff;
        logic        fv;
        logic        pass;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic s_done(input int w);  return (w != 0) ? done1 : done0; endfunction
    function automatic logic s_busy(input int w);  return (w != 0) ? busy1 : busy0; endfunction
    function automatic logic [3:0] s_abcd(input int w); return (w != 0) ? abcd1 : abcd0; endfunction
    function automatic logic [15:0] s_tt(input int w); return (w != 0) ? tt1 : tt0; endfunction
    function automatic logic [4:0] s_mc(input int w); return (w != 0) ? mc1 : mc0; endfunction
    function automatic logic [3:0] s_ff(input int w); return (w != 0) ? ff1 : ff0; endfunction
    function automatic logic s_fv(input int w);    return (w != 0) ? fv1 : fv0; endfunction
    function automatic logic s_pass(input int w);  return (w != 0) ? pass1 : pass0; endfunction

    // Starts a sweep and returns at the falling edge of the done cycle
    // (dcyc = cycles after the start edge, -1 if done never arrived).
    task automatic run_sweep(input int which, input logic [15:0] u, input logic [15:0] e,
                             output int dcyc, output logic seq_ok);
        int s;
        s = (which != 0) ? 1 : 2;
        if (which != 0) begin unit1 = u; expect1 = e; start1 = 1'b1; end
        else            begin unit0 = u; expect0 = e; start0 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        dcyc   = -1;
        seq_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (s_done(which)) begin
                dcyc = c;
                break;
            end
            if (s_abcd(which) != 4'((c - 1) / s) || !s_busy(which))
                seq_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int   dcyc;
        logic seq_ok;
        int   npulse;
        logic found;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start0 = 0; abort0 = 0; expect0 = '0; unit0 = '0;
        start1 = 0; abort1 = 0; expect1 = '0; unit1 = '0;

        vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 33, 16'hA5C3, 5'd0,  4'd0,  1'b0, 1'b1};
        vecs[1] = '{0, 16'hA5C3, 16'hA1CB, 33, 16'hA5C3, 5'd2,  4'd3,  1'b1, 1'b0};
        vecs[2] = '{0, 16'h0000, 16'hFFFF, 33, 16'h0000, 5'd16, 4'd0,  1'b1, 1'b0};
        vecs[3] = '{0, 16'hFFFF, 16'h7FFF, 33, 16'hFFFF, 5'd1,  4'd15, 1'b1, 1'b0};
        vecs[4] = '{0, 16'h1234, 16'h1235, 33, 16'h1234, 5'd1,  4'd0,  1'b1, 1'b0};
        vecs[5] = '{1, 16'hFFFF, 16'hFFFF, 17, 16'hFFFF, 5'd0,  4'd0,  1'b0, 1'b1};
        vecs[6] = '{1, 16'hFFFF, 16'h0000, 17, 16'hFFFF, 5'd16, 4'd0,  1'b1, 1'b0};

        #12;
        chk("rst_outputs0", {abcd0, busy0, done0, tt0, pass0, mc0, ff0, fv0}, '0);
        chk("rst_outputs1", {abcd1, busy1, done1, tt1, pass1, mc1, ff1, fv1}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_sweep(vecs[i].which, vecs[i].ufn, vecs[i].exp_in, dcyc, seq_ok);
            chk($sformatf("v%0d_done_cycle", i), dcyc, vecs[i].dcyc);
            chk($sformatf("v%0d_abcd_seq", i), seq_ok, 1);
            chk($sformatf("v%0d_busy_in_done", i), s_busy(vecs[i].which), 1);
            chk($sformatf("v%0d_tt", i), s_tt(vecs[i].which), vecs[i].tt);
            chk($sformatf("v%0d_mismatch", i), s_mc(vecs[i].which), vecs[i].mc);
            chk($sformatf("v%0d_first_fail", i), s_ff(vecs[i].which), vecs[i].ff);
            chk($sformatf("v%0d_fail_valid", i), s_fv(vecs[i].which), vecs[i].fv);
            chk($sformatf("v%0d_pass", i), s_pass(vecs[i].which), vecs[i].pass);
            @(negedge clk);
            chk($sformatf("v%0d_after_busy_done", i),
                {s_busy(vecs[i].which), s_done(vecs[i].which)}, 2'b00);
            chk($sformatf("v%0d_pass_held", i), s_pass(vecs[i].which), vecs[i].pass);
            @(negedge clk);
        end

        // Restarts during a sweep and in DONE are ignored; expect_tt change mid-sweep has no effect.
        unit0 = 16'hA5C3; expect0 = 16'hA5C3; start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        npulse = 0;
        for (int c = 1; c <= 35; c++) begin
            if (done0) npulse++;
            if (c == 33) chk("t3_done_at_33", done0, 1);
            if (c == 34) begin
                chk("t3_busy_low_34", busy0, 0);
                chk("t3_pass_latched", pass0, 1);
            end
            if (c == 10) expect0 = 16'h0000;
            start0 = (c == 5 || c == 33 || c == 35);
            @(negedge clk);
        end
        start0 = 1'b0;
        chk("t3_single_done", npulse, 1);
        chk("t3_restart_busy", busy0, 1);
        chk("t3_restart_abcd", abcd0, 0);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("t3_abort_idle", busy0, 0);
        @(negedge clk);

        // Abort while vector 5 is driven keeps the partial capture.
        unit0 = 16'hA5C3; expect0 = 16'hA1CB; start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        found = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (abcd0 == 4'd5) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t4_reach_abcd5", found, 1);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("t4_busy", busy0, 0);
        chk("t4_abcd", abcd0, 0);
        chk("t4_tt_partial", tt0, 16'h0003);
        chk("t4_mismatch", mc0, 1);
        chk("t4_first_fail", ff0, 3);
        chk("t4_fail_valid", fv0, 1);
        chk("t4_pass", pass0, 0);
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            if (done0 || busy0) npulse++;
            @(negedge clk);
        end
        chk("t4_no_done_after_abort", npulse, 0);

        // Asynchronous reset mid-sweep clears outputs before any clock edge.
        unit0 = 16'hA5C3; expect0 = 16'hA5C3; start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        found = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (abcd0 == 4'd9) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t5_reach_abcd9", found, 1);
        chk("t5_tt_nonzero_before", (tt0 != 16'h0000), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_clear", {abcd0, busy0, done0, tt0, pass0, mc0, ff0, fv0}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(0, 16'hA5C3, 16'hA5C3, dcyc, seq_ok);
        chk("t5_post_done_cycle", dcyc, 33);
        chk("t5_post_seq", seq_ok, 1);
        chk("t5_post_tt", tt0, 16'hA5C3);
        chk("t5_post_pass", pass0, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
